ifetch_unit: RTL

//  Fetch stage. Keeps the PC, issues one i-cache request at a time and presents each fetched PC to the branch predictor.

---
 rtl/ifetch_unit.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage.
// Keeps the PC, issues one i-cache request at a time and computes the next PC
// from the returned instruction: B-type branches, JAL redirects and flushes.
// Fetched instructions are buffered in a circular FIFO for issue/decode.
// Optional feature macro: IFETCH_PRED_EN
//   defined   -> B-type direction comes from the external branch predictor
//   undefined -> static backward-taken / forward-not-taken (instr[31])
module ifetch_unit #(
    parameter int          IQ_WIDTH = 4,
    parameter int          IQ_DEPTH = 2**IQ_WIDTH,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req_out,
    output logic [31:0] icache_addr_out,
    input  logic        icache_valid_in,
    input  logic [31:0] icache_instr_in,
    output logic [9:0]  pred_addr_out,
    input  logic        pred_taken_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    output logic        iq_valid_out,
    output logic [31:0] iq_instr_out,
    output logic [31:0] iq_pc_out,
    output logic        iq_pred_taken_out,
    input  logic        iq_pop_in
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PREDICT = 2'd2
    } state_t;

    localparam logic [6:0]        OP_BRANCH  = 7'b1100011;
    localparam logic [6:0]        OP_JAL     = 7'b1101111;
    localparam logic [IQ_WIDTH:0] FULL_COUNT = (IQ_WIDTH+1)'(IQ_DEPTH);
    localparam int                ENTRY_W    = 65;

    // Fetch control state
    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic        drop_reg, drop_next;
    logic        req_reg, req_next;

    // Instruction queue state
    logic [IQ_WIDTH-1:0] head_reg, head_next;
    logic [IQ_WIDTH-1:0] tail_reg, tail_next;
    logic [IQ_WIDTH:0]   count_reg, count_next;
    logic [ENTRY_W-1:0]  iq_mem [IQ_DEPTH];
    logic [ENTRY_W-1:0]  head_entry;

    // Decode / next-PC signals
    logic        flush_act;
    logic        iq_push;
    logic        iq_pop;
    logic        branch_taken;
    logic        pred_taken;
    logic [31:0] next_pc;
    logic [31:0] b_imm;
    logic [31:0] j_imm;
    logic [6:0]  opcode;

    assign flush_act = rdy_in && flush_in;
    assign iq_push   = rdy_in && !flush_in && (state_reg == ST_PREDICT);
    assign iq_pop    = rdy_in && !flush_in && iq_pop_in && (count_reg != '0);

    // Immediates of the latched instruction, sign-extended to 32 bits
    assign opcode = instr_reg[6:0];
    assign b_imm  = {{19{instr_reg[31]}}, instr_reg[31], instr_reg[7],
                     instr_reg[30:25], instr_reg[11:8], 1'b0};
    assign j_imm  = {{11{instr_reg[31]}}, instr_reg[31], instr_reg[19:12],
                     instr_reg[20], instr_reg[30:21], 1'b0};

`ifdef IFETCH_PRED_EN
    assign branch_taken = pred_taken_in;
`else
    // Backward branches (negative offset) are predicted taken; the predictor
    // input is not consulted in this build.
    logic pred_taken_unused;
    assign pred_taken_unused = pred_taken_in;
    assign branch_taken      = instr_reg[31];
`endif

    // Next-PC and taken flag for the instruction held in PREDICT
    always_comb begin
        pred_taken = 1'b0;
        next_pc    = pc_reg + 32'd4;
        case (opcode)
            OP_BRANCH: begin
                pred_taken = branch_taken;
                if (branch_taken) begin
                    next_pc = pc_reg + b_imm;
                end
            end
            OP_JAL: begin
                pred_taken = 1'b1;
                next_pc    = pc_reg + j_imm;
            end
            default: begin
                pred_taken = 1'b0;
            end
        endcase
    end

    // Fetch FSM next-state logic; flush overrides everything else
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        drop_next  = drop_reg;
        req_next   = 1'b0;
        if (flush_act) begin
            state_next = ST_IDLE;
            pc_next    = flush_pc_in;
            if (state_reg == ST_WAIT && !icache_valid_in) begin
                // The outstanding response will still arrive; discard it.
                drop_next = 1'b1;
            end else if (drop_reg && icache_valid_in) begin
                drop_next = 1'b0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (drop_reg) begin
                        // Hold off new requests until the stale response is gone
                        if (icache_valid_in) begin
                            drop_next = 1'b0;
                        end
                    end else if (count_reg != FULL_COUNT) begin
                        req_next   = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (icache_valid_in) begin
                        instr_next = icache_instr_in;
                        state_next = ST_PREDICT;
                    end
                end
                ST_PREDICT: begin
                    pc_next    = next_pc;
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Fetch FSM registers; frozen while rdy_in is low
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= '0;
            drop_reg  <= 1'b0;
        end else if (rdy_in) begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            drop_reg  <= drop_next;
        end
    end

    // Request pulse register; never asserted while rdy_in is low
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            req_reg <= 1'b0;
        end else begin
            req_reg <= rdy_in && req_next;
        end
    end

    // Queue pointer and occupancy next-state
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush_act) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (iq_push) begin
                tail_next = tail_reg + 1'b1;
            end
            if (iq_pop) begin
                head_next = head_reg + 1'b1;
            end
            case ({iq_push, iq_pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    // Queue pointer registers; frozen while rdy_in is low
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (rdy_in) begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Queue storage: entry = {taken, pc, instr}; no reset needed because
    // outputs are gated by the occupancy count
    always_ff @(posedge clk_in) begin
        if (iq_push) begin
            iq_mem[tail_reg] <= {pred_taken, pc_reg, instr_reg};
        end
    end

    assign head_entry = iq_mem[head_reg];

    assign icache_req_out    = req_reg;
    assign icache_addr_out   = pc_reg;
    assign pred_addr_out     = pc_reg[11:2];
    assign iq_valid_out      = (count_reg != '0);
    assign iq_instr_out      = iq_valid_out ? head_entry[31:0]  : 32'd0;
    assign iq_pc_out         = iq_valid_out ? head_entry[63:32] : 32'd0;
    assign iq_pred_taken_out = iq_valid_out && head_entry[64];

endmodule
